// File: rtl/bg_object_renderer_pkg.sv
// Shared constants and types for the background-object (cloud) renderer.
// Sprite geometry, default VGA timing and the line-fetch FSM state enum.
package bg_object_renderer_pkg;

  localparam int unsigned SPRITE_W     = 16;
  localparam int unsigned SPRITE_H     = 8;
  localparam int unsigned ROW_AW       = 3;
  localparam int unsigned POS_W        = 10;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_TOTAL_DEF  = 525;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    FETCH1,
    FETCH2
  } bg_state_e;

endpackage

// File: rtl/bg_sprite_rom.sv
// Cloud bitmap ROM, 16 texels x 8 rows, combinational lookup.
// Ports: row (texel row index) -> row_bits_c (MSB = leftmost texel).
module bg_sprite_rom
  import bg_object_renderer_pkg::*;
(
  input  logic [ROW_AW-1:0]   row,
  output logic [SPRITE_W-1:0] row_bits_c
);

  always_comb begin
    row_bits_c = '0;
    case (row)
      3'd0: row_bits_c = 16'h01C0;
      3'd1: row_bits_c = 16'h07F0;
      3'd2: row_bits_c = 16'h1FF8;
      3'd3: row_bits_c = 16'h3FFE;
      3'd4: row_bits_c = 16'hFFFF;
      3'd5: row_bits_c = 16'h7FFC;
      3'd6: row_bits_c = 16'h1E78;
      3'd7: row_bits_c = 16'h0C30;
    endcase
  end

endmodule

// File: rtl/bg_object_renderer.sv
// Background-object renderer: per-pixel "cloud present" flag for two objects.
// Rows are fetched during horizontal blank into staging registers, then
// streamed through per-object shift registers during active video.
// Ports: clk, rst_n (sync, active-low), hpos/vpos (beam), bg_object1_pos /
// bg_object2_pos (0 = hidden), bg_pixel_on (registered, 1-cycle latency).
// Optional: define BG_OBJ_FLIP_EN to draw object 2 horizontally mirrored.
module bg_object_renderer
  import bg_object_renderer_pkg::*;
#(
  parameter int unsigned CONV       = 0,
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned V_TOTAL    = V_TOTAL_DEF,
  parameter int unsigned OBJ1_Y     = 40,
  parameter int unsigned OBJ2_Y     = 72,
  parameter int unsigned SCALE_LOG2 = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            hpos,
  input  logic [9:0]            vpos,
  input  logic [POS_W-CONV-1:0] bg_object1_pos,
  input  logic [POS_W-CONV-1:0] bg_object2_pos,
  output logic                  bg_pixel_on
);

  localparam int unsigned TEX_PIX  = 1 << SCALE_LOG2;
  localparam int unsigned ROW_SPAN = SPRITE_H << SCALE_LOG2;
  localparam int unsigned RUN_LEN  = SPRITE_W << SCALE_LOG2;
  localparam int unsigned RUN_W    = $clog2(RUN_LEN + 1);
  localparam int unsigned SUB_W    = (SCALE_LOG2 == 0) ? 1 : SCALE_LOG2;

  bg_state_e             state_q;
  logic [9:0]            x_q     [2];
  logic                  valid_q [2];
  logic [SPRITE_W-1:0]   stage_q [2];
  logic [SPRITE_W-1:0]   sh_q    [2];
  logic [RUN_W-1:0]      run_q   [2];
  logic [SUB_W-1:0]      sub_q   [2];

  logic [SPRITE_W-1:0]   sh_n    [2];
  logic [RUN_W-1:0]      run_n   [2];
  logic [SUB_W-1:0]      sub_n   [2];
  logic [SPRITE_W-1:0]   cur_sh_c  [2];
  logic [RUN_W-1:0]      cur_run_c [2];
  logic [SUB_W-1:0]      cur_sub_c [2];
  logic [1:0]            start_c;
  logic [1:0]            obj_bit_c;
  logic                  active_c;

  logic [9:0]            nline_c;
  logic signed [10:0]    d1_c, d2_c;
  logic                  ok1_c, ok2_c;
  logic [ROW_AW-1:0]     rom_sel_c;
  logic [SPRITE_W-1:0]   rom_row_c;
  logic [SPRITE_W-1:0]   obj2_row_c;

  // Row offsets of the upcoming line relative to each object's top edge.
  assign nline_c = (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
  assign d1_c    = $signed({1'b0, nline_c}) - $signed(11'(OBJ1_Y));
  assign d2_c    = $signed({1'b0, nline_c}) - $signed(11'(OBJ2_Y));
  assign ok1_c   = !d1_c[10] && (d1_c < $signed(11'(ROW_SPAN))) && (x_q[0] != 10'd0);
  assign ok2_c   = !d2_c[10] && (d2_c < $signed(11'(ROW_SPAN))) && (x_q[1] != 10'd0);

  // One ROM shared between the two fetch states.
  assign rom_sel_c = (state_q == FETCH2) ? ROW_AW'($unsigned(d2_c) >> SCALE_LOG2)
                                         : ROW_AW'($unsigned(d1_c) >> SCALE_LOG2);

  bg_sprite_rom u_rom (
    .row        (rom_sel_c),
    .row_bits_c (rom_row_c)
  );

`ifdef BG_OBJ_FLIP_EN
  assign obj2_row_c = {<<{rom_row_c}};
`else
  assign obj2_row_c = rom_row_c;
`endif

  // Per-object streaming: a start pixel bypasses the shift register so the
  // first texel appears at x_i itself; runs are killed outside active video.
  always_comb begin
    active_c  = hpos < 10'(H_ACTIVE);
    start_c   = '0;
    obj_bit_c = '0;
    for (int i = 0; i < 2; i++) begin
      sh_n[i]      = sh_q[i];
      run_n[i]     = run_q[i];
      sub_n[i]     = sub_q[i];
      start_c[i]   = active_c && valid_q[i] && (hpos == x_q[i]);
      cur_sh_c[i]  = start_c[i] ? stage_q[i] : sh_q[i];
      cur_run_c[i] = start_c[i] ? RUN_W'(RUN_LEN) : run_q[i];
      cur_sub_c[i] = start_c[i] ? '0 : sub_q[i];
      obj_bit_c[i] = active_c && (cur_run_c[i] != '0) && cur_sh_c[i][SPRITE_W-1];
      if (!active_c) begin
        run_n[i] = '0;
      end else if (cur_run_c[i] != '0) begin
        run_n[i] = cur_run_c[i] - RUN_W'(1);
        if (cur_sub_c[i] == SUB_W'(TEX_PIX - 1)) begin
          sh_n[i]  = cur_sh_c[i] << 1;
          sub_n[i] = '0;
        end else begin
          sh_n[i]  = cur_sh_c[i];
          sub_n[i] = cur_sub_c[i] + SUB_W'(1);
        end
      end
    end
  end

  // Line-fetch FSM plus all streaming and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bg_pixel_on <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        x_q[i]     <= '0;
        valid_q[i] <= 1'b0;
        stage_q[i] <= '0;
        sh_q[i]    <= '0;
        run_q[i]   <= '0;
        sub_q[i]   <= '0;
      end
    end else begin
      bg_pixel_on <= |obj_bit_c;
      for (int i = 0; i < 2; i++) begin
        sh_q[i]  <= sh_n[i];
        run_q[i] <= run_n[i];
        sub_q[i] <= sub_n[i];
      end
      case (state_q)
        IDLE: begin
          if (hpos == 10'(H_ACTIVE)) state_q <= LATCH;
        end
        LATCH: begin
          x_q[0]  <= 10'(10'(bg_object1_pos) << CONV);
          x_q[1]  <= 10'(10'(bg_object2_pos) << CONV);
          state_q <= FETCH1;
        end
        FETCH1: begin
          valid_q[0] <= ok1_c;
          if (ok1_c) stage_q[0] <= rom_row_c;
          state_q <= FETCH2;
        end
        FETCH2: begin
          valid_q[1] <= ok2_c;
          if (ok2_c) stage_q[1] <= obj2_row_c;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bg_object_renderer.sv
// Self-checking bench for bg_object_renderer: two instances (object 2 at its
// own band, and object 2 sharing object 1's band) against a behavioural model
// that draws each line from the positions/rows captured at the previous blank.
module tb_bg_object_renderer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] hpos, vpos;
  logic [9:0] pos1, pos2;
  logic       pix0, pix1;

  int checks = 0;
  int errors = 0;
  int grp    = 0;

  always #5 clk = ~clk;

  bg_object_renderer #(.CONV(0), .H_ACTIVE(640), .V_TOTAL(525), .OBJ1_Y(40),
                       .OBJ2_Y(72), .SCALE_LOG2(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos),
    .bg_object1_pos(pos1), .bg_object2_pos(pos2), .bg_pixel_on(pix0));

  bg_object_renderer #(.CONV(0), .H_ACTIVE(640), .V_TOTAL(525), .OBJ1_Y(40),
                       .OBJ2_Y(40), .SCALE_LOG2(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos),
    .bg_object1_pos(pos1), .bg_object2_pos(pos2), .bg_pixel_on(pix1));

  // Reference cloud bitmap, leftmost texel in bit 15.
  bit [15:0] rom_m [8] = '{16'h01C0, 16'h07F0, 16'h1FF8, 16'h3FFE,
                           16'hFFFF, 16'h7FFC, 16'h1E78, 16'h0C30};

  int        m_x   [2][2];
  bit        m_v   [2][2];
  bit [15:0] m_row [2][2];
  bit        exp_q [2];
  int        s_h, s_v;
  bit        armed = 1'b0;

  function automatic bit [15:0] rev16(input bit [15:0] w);
    bit [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = w[15-i];
    return r;
  endfunction

  // Pixel h of a 32-pixel-wide, 2x-scaled sprite row placed at x.
  function automatic bit obj_pix(input int h, input int x, input bit v, input bit [15:0] row);
    if (!v || h >= 640 || h < x || h >= x + 32) return 1'b0;
    return row[15 - ((h - x) / 2)];
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        exp_q[d] = 1'b0;
        for (int o = 0; o < 2; o++) begin
          m_v[d][o] = 1'b0;
          m_x[d][o] = 0;
        end
      end else begin
        exp_q[d] = obj_pix(int'(hpos), m_x[d][0], m_v[d][0], m_row[d][0]) |
                   obj_pix(int'(hpos), m_x[d][1], m_v[d][1], m_row[d][1]);
        if (hpos == 10'd640) begin
          int nl, y, dd, p;
          nl = (vpos == 10'd524) ? 0 : int'(vpos) + 1;
          for (int o = 0; o < 2; o++) begin
            y  = (o == 0) ? 40 : ((d == 0) ? 72 : 40);
            p  = (o == 0) ? int'(pos1) : int'(pos2);
            dd = nl - y;
            m_x[d][o] = p;
            m_v[d][o] = (dd >= 0) && (dd < 16) && (p != 0);
            if (m_v[d][o]) begin
              m_row[d][o] = rom_m[dd / 2];
`ifdef BG_OBJ_FLIP_EN
              if (o == 1) m_row[d][o] = rev16(rom_m[dd / 2]);
`endif
            end
          end
        end
      end
    end
    s_h   = int'(hpos);
    s_v   = int'(vpos);
    armed = 1'b1;
  end

  task automatic chk(input string name, input bit act, input bit expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s line %0d x %0d: got %0b expected %0b", name, s_v, s_h, act, expv);
    end
  endtask

  task automatic lit(input int d, input int v, input int h, input bit expv);
    if (s_v == v && s_h == h) chk("literal", (d == 0) ? pix0 : pix1, expv);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("model_dut0", pix0, exp_q[0]);
      chk("model_dut1", pix1, exp_q[1]);
      if (grp == 1) begin
        lit(0, 40, 113, 0); lit(0, 40, 114, 1); lit(0, 40, 119, 1); lit(0, 40, 120, 0);
        lit(0, 48, 99, 0);  lit(0, 48, 100, 1); lit(0, 48, 131, 1); lit(0, 48, 132, 0);
        lit(0, 45, 120, 0); lit(0, 46, 120, 1); lit(0, 46, 103, 0); lit(0, 46, 104, 1);
      end
      if (grp == 2) begin
        lit(0, 48, 629, 0); lit(0, 48, 630, 1); lit(0, 48, 639, 1); lit(0, 49, 0, 0);
      end
      if (grp == 3) begin
        lit(0, 45, 205, 0); lit(0, 45, 206, 1); lit(0, 46, 202, 0); lit(0, 46, 203, 1);
      end
      if (grp == 4) begin
        lit(1, 40, 314, 1); lit(1, 48, 331, 1); lit(1, 48, 332, 0); lit(0, 40, 313, 0);
      end
    end
  end

  // One full 800-pixel line; optional mid-line position change and reset pulse.
  task automatic run_line(input int v, input int p1, input int p2,
                          input int chg_h, input int p1_new, input bit do_rst);
    for (int h = 0; h < 800; h++) begin
      @(negedge clk);
      hpos = 10'(h);
      vpos = 10'(v);
      if (h == 0) begin
        pos1 = 10'(p1);
        pos2 = 10'(p2);
      end
      if (chg_h >= 0 && h == chg_h) pos1 = 10'(p1_new);
      rst_n = do_rst ? !(h >= 50 && h < 60) : 1'b1;
    end
  endtask

  function automatic int rnd_pos();
    if ($urandom_range(0, 3) == 0) return 0;
    return int'($urandom_range(1, 1023));
  endfunction

  initial begin
    rst_n = 1'b0;
    hpos  = '0;
    vpos  = '0;
    pos1  = '0;
    pos2  = '0;
    repeat (5) @(negedge clk);

    grp = 1;
    for (int v = 38; v <= 57; v++) run_line(v, 100, 0, -1, 0, v == 45);

    grp = 2;
    for (int v = 47; v <= 49; v++) run_line(v, 630, 0, -1, 0, 1'b0);

    grp = 3;
    run_line(44, 200, 0, -1, 0, 1'b0);
    run_line(45, 200, 0, 300, 199, 1'b0);
    run_line(46, 199, 0, -1, 0, 1'b0);

    grp = 4;
    for (int v = 39; v <= 56; v++) run_line(v, 300, 300, -1, 0, 1'b0);

    grp = 5;
    for (int v = 71; v <= 88; v++) run_line(v, int'($urandom_range(1, 639)), 0, -1, 0, 1'b0);

    grp = 6;
    for (int n = 0; n < 10; n++)
      run_line(int'($urandom_range(30, 95)), rnd_pos(), rnd_pos(), -1, 0, 1'b0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bg_object_renderer.md
Name: bg_object_renderer

Overview:
- Downstream consumer of the background-object position generator.
- Takes the two background-object positions (clouds) and the VGA beam position, and produces a 1-bit per-pixel "background object present" signal for the colour mixer.
- Sprite rows are fetched during horizontal blank into per-object shift registers, then streamed out during active video.

Parameters:
- CONV, 0: position LSB index; screen x = pos << CONV; must match the position generator.
- H_ACTIVE, 640: active pixels per line.
- V_TOTAL, 525: total lines per frame.
- OBJ1_Y, 40: top screen row of object 1.
- OBJ2_Y, 72: top screen row of object 2.
- SCALE_LOG2, 1: each sprite texel is drawn as 2^SCALE_LOG2 x 2^SCALE_LOG2 pixels.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous, active-low reset
- hpos  in  10  current beam x, 0..799
- vpos  in  10  current beam y, 0..V_TOTAL-1
- bg_object1_pos  in  10-CONV  object 1 x position; 0 = hidden
- bg_object2_pos  in  10-CONV  object 2 x position; 0 = hidden
- bg_pixel_on  out  1  registered; 1 when either object covers the pixel

Behaviour:
- Reset values: bg_pixel_on=0, FSM=IDLE, both shift registers=0, latched x positions=0, row-valid flags=0.
- Sprite geometry: 16 texels wide x 8 texels tall, held in sub-module ROM. Screen footprint is (16<<SCALE_LOG2) x (8<<SCALE_LOG2).
- Next line: nline = (vpos==V_TOTAL-1) ? 0 : vpos+1.
- FSM states: IDLE -> LATCH -> FETCH1 -> FETCH2 -> IDLE.
  - IDLE -> LATCH when hpos==H_ACTIVE.
  - LATCH: snapshot both positions as x1 = pos1<<CONV and x2 = pos2<<CONV, zero-extended to 10 bits.
  - FETCH1/FETCH2: per object i, d = nline - OBJi_Y in 11-bit signed arithmetic.
    - Row is valid iff 0 <= d < 8<<SCALE_LOG2 and pos != 0.
    - If valid, load row word ROM[d>>SCALE_LOG2] into the staging register and set valid_i.
    - Otherwise clear valid_i.
  - Position changes during a line never affect that line; they take effect at the next LATCH.
- Active streaming (hpos < H_ACTIVE), per object:
  - When hpos==x_i and valid_i: copy staging into the shift register and reset a texel sub-counter.
  - Output bit = shift register MSB, asserted while the object run counter is nonzero. Run length = 16<<SCALE_LOG2 pixels.
  - Shift left one texel every 2^SCALE_LOG2 pixels.
- Boundaries:
  - Objects with x_i >= H_ACTIVE draw nothing on that line.
  - Objects extending past H_ACTIVE-1 are clipped: output is forced to 0 when hpos >= H_ACTIVE.
  - x_i == 0 never draws (hidden).
  - Overlapping objects: output is the OR of both.
- Latency: bg_pixel_on at cycle t+1 reflects hpos/vpos sampled at cycle t (1 cycle, fixed).
- Reset asserted mid-line: all state is cleared. Output stays 0 until the first full LATCH/FETCH sequence after reset deasserts.
- Staging registers are retained across lines but are gated by valid_i.

Optional Feature:
- BG_OBJ_FLIP_EN defined: object 2 is drawn horizontally mirrored. The row word is bit-reversed on load into staging, giving visual variety from a single ROM.
- Undefined: both objects use the ROM row unmodified, and no reversal logic is present.

Decomposition:
- Shared package holds:
  - SPRITE_W=16, SPRITE_H=8.
  - The FSM state enum (IDLE, LATCH, FETCH1, FETCH2).
  - H_ACTIVE/V_TOTAL defaults shared with the VGA timing block.
- Sub-module bg_sprite_rom: combinational, 3-bit row in, 16-bit row out; holds the cloud bitmap.

Test Plan:
- Reset held for 10 cycles mid-line, then released -> bg_pixel_on=0 for the remainder of that line; drawing starts on the next line containing an object.
- pos1=100, CONV=0, SCALE_LOG2=1, vpos runs OBJ1_Y-1..OBJ1_Y+16 -> pixels asserted only at x 100..131 on lines 40..55, matching ROM rows row=(y-40)>>1, each texel 2 pixels wide, 1-cycle latency.
- pos1=630 -> only x 630..639 drawn; nothing wraps to x 0 of the next line.
- pos1 changed from 200 to 199 while hpos=300 -> current line drawn at 200; next line drawn at 199.
- pos2=0 with vpos in the object-2 band -> bg_pixel_on never asserts for object 2. pos1=pos2=300 on a shared row (OBJ2_Y set to OBJ1_Y) -> output equals the OR of both rows.
- BG_OBJ_FLIP_EN defined, pos2=300 -> object-2 row equals the bit-reversed ROM row; object 1 is unchanged.
